// File: rtl/dmem_pkg.sv
// Shared types, default sizes and the byte-merge helper for the handshaked data memory.
package dmem_pkg;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        RESP  = 2'd2
    } dmem_state_t;

    localparam int DMEM_DWIDTH     = 32;
    localparam int DMEM_DEPTH      = 128;
    localparam int DMEM_MAX_DWIDTH = 256;
    localparam int DMEM_MAX_BE     = DMEM_MAX_DWIDTH / 8;

    // Works on the widest supported word; callers zero-extend and truncate to their own width.
    function automatic logic [DMEM_MAX_DWIDTH-1:0] dmem_byte_merge(
        input logic [DMEM_MAX_DWIDTH-1:0] old_word,
        input logic [DMEM_MAX_DWIDTH-1:0] new_word,
        input logic [DMEM_MAX_BE-1:0]     be
    );
        logic [DMEM_MAX_DWIDTH-1:0] merged;
        merged = old_word;
        for (int i = 0; i < DMEM_MAX_BE; i++) begin
            if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/dmem_clear_seq.sv
// Zeroing-sweep pointer for dmem_hs: walks 0..DEPTH-1 while active and can be restarted at 0.
module dmem_clear_seq
    import dmem_pkg::*;
#(
    parameter int DEPTH  = DMEM_DEPTH,
    parameter int AWIDTH = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_active,
    input  logic              i_restart,
    output logic [AWIDTH-1:0] o_ptr,
    output logic              o_we,
    output logic              o_done
);

    logic [AWIDTH-1:0] r_ptr;
    logic              w_last;

    assign w_last = (r_ptr == AWIDTH'(DEPTH - 1));
    assign o_ptr  = r_ptr;
    assign o_we   = i_active;
    assign o_done = i_active && w_last && !i_restart;

    // Pointer parks at 0 outside the sweep so the next entry into CLEAR starts cleanly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= '0;
        end else if (i_restart || o_done) begin
            r_ptr <= '0;
        end else if (i_active) begin
            r_ptr <= r_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/dmem_hs.sv
// Parametrised single-port data memory with valid/ready handshake, byte enables and range errors.
// Optional access counters are built when DMEM_STATS_EN is defined.
module dmem_hs
    import dmem_pkg::*;
#(
    parameter int DWIDTH = DMEM_DWIDTH,
    parameter int DEPTH  = DMEM_DEPTH,
    parameter int AWIDTH = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [AWIDTH-1:0]   req_addr,
    input  logic [DWIDTH-1:0]   req_wdata,
    input  logic [DWIDTH/8-1:0] req_be,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DWIDTH-1:0]   resp_rdata,
    output logic                resp_err,
    output logic                busy
`ifdef DMEM_STATS_EN
    ,
    output logic [15:0]         rd_count,
    output logic [15:0]         wr_count
`endif
);

    dmem_state_t       r_state;
    dmem_state_t       w_next;
    logic              r_clr_pend;
    logic              r_resp_valid;
    logic              r_resp_err;
    logic [DWIDTH-1:0] r_resp_rdata;
    logic [DWIDTH-1:0] r_mem [DEPTH];

    logic              w_in_range;
    logic              w_accept;
    logic              w_enter_clear;
    logic              w_clr_we;
    logic              w_clr_done;
    logic [AWIDTH-1:0] w_clr_ptr;
    logic [DWIDTH-1:0] w_old_word;
    logic [DWIDTH-1:0] w_merged;

    dmem_clear_seq #(
        .DEPTH  (DEPTH),
        .AWIDTH (AWIDTH)
    ) u_clear_seq (
        .clk       (clk),
        .rst       (rst),
        .i_active  (r_state == CLEAR),
        .i_restart (clr && (r_state == CLEAR)),
        .o_ptr     (w_clr_ptr),
        .o_we      (w_clr_we),
        .o_done    (w_clr_done)
    );

    assign w_in_range = (32'(req_addr) < 32'(DEPTH));
    assign w_old_word = w_in_range ? r_mem[req_addr] : '0;
    assign w_merged   = DWIDTH'(dmem_byte_merge(DMEM_MAX_DWIDTH'(w_old_word),
                                                DMEM_MAX_DWIDTH'(req_wdata),
                                                DMEM_MAX_BE'(req_be)));

    // A clear request always wins over a new request in the same cycle.
    assign req_ready = !clr && ((r_state == IDLE) ||
                                ((r_state == RESP) && resp_ready && !r_clr_pend));
    assign w_accept  = req_valid && req_ready;

    always_comb begin
        w_next = r_state;
        case (r_state)
            CLEAR: if (w_clr_done) w_next = IDLE;
            IDLE: begin
                if (clr)           w_next = CLEAR;
                else if (w_accept) w_next = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    if (w_accept)                w_next = RESP;
                    else if (r_clr_pend || clr)  w_next = CLEAR;
                    else                         w_next = IDLE;
                end
            end
            default: w_next = CLEAR;
        endcase
    end

    assign w_enter_clear = (w_next == CLEAR) && (r_state != CLEAR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= CLEAR;
            r_clr_pend <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_enter_clear)                   r_clr_pend <= 1'b0;
            else if ((r_state == RESP) && clr)   r_clr_pend <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else if (w_accept) begin
            r_resp_valid <= 1'b1;
            r_resp_rdata <= w_old_word;
            r_resp_err   <= !w_in_range;
        end else if ((r_state == RESP) && resp_ready) begin
            r_resp_valid <= 1'b0;
        end
    end

    // Storage is deliberately not on rst; the sweep is what zeroes it.
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[w_clr_ptr] <= '0;
        end else if (w_accept && req_we && w_in_range && (|req_be)) begin
            r_mem[req_addr] <= w_merged;
        end
    end

`ifdef DMEM_STATS_EN
    logic [15:0] r_rd_count;
    logic [15:0] r_wr_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_count <= '0;
            r_wr_count <= '0;
        end else if (w_enter_clear) begin
            r_rd_count <= '0;
            r_wr_count <= '0;
        end else if (w_accept && w_in_range) begin
            if (req_we) begin
                if (r_wr_count != 16'hFFFF) r_wr_count <= r_wr_count + 1'b1;
            end else begin
                if (r_rd_count != 16'hFFFF) r_rd_count <= r_rd_count + 1'b1;
            end
        end
    end

    assign rd_count = r_rd_count;
    assign wr_count = r_wr_count;
`endif

    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;
    assign busy       = (r_state == CLEAR);

endmodule

// File: tb/tb_dmem_hs.sv
// Bench for dmem_hs: a DEPTH=128 instance driven through a response scoreboard,
// plus a DEPTH=100 instance for out-of-range addressing.
module tb_dmem_hs;

    localparam int DEPTH_A = 128;
    localparam int DEPTH_B = 100;

    logic        clk;
    logic        rst;

    logic        clr;
    logic        reqValid;
    logic        reqReady;
    logic        reqWe;
    logic [6:0]  reqAddr;
    logic [31:0] reqWdata;
    logic [3:0]  reqBe;
    logic        respValid;
    logic        respReady;
    logic [31:0] respRdata;
    logic        respErr;
    logic        busy;

    logic        bReqValid;
    logic        bReqReady;
    logic        bReqWe;
    logic [6:0]  bReqAddr;
    logic [31:0] bReqWdata;
    logic [3:0]  bReqBe;
    logic        bRespValid;
    logic        bRespReady;
    logic [31:0] bRespRdata;
    logic        bRespErr;
    logic        bBusy;

`ifdef DMEM_STATS_EN
    logic [15:0] rdCount;
    logic [15:0] wrCount;
    logic [15:0] bRdCount;
    logic [15:0] bWrCount;
`endif

    int          checkCount = 0;
    int          failCount  = 0;
    logic [32:0] expQ[$];
    logic [32:0] expEntry;

    dmem_hs #(.DWIDTH(32), .DEPTH(DEPTH_A)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .req_valid  (reqValid),
        .req_ready  (reqReady),
        .req_we     (reqWe),
        .req_addr   (reqAddr),
        .req_wdata  (reqWdata),
        .req_be     (reqBe),
        .resp_valid (respValid),
        .resp_ready (respReady),
        .resp_rdata (respRdata),
        .resp_err   (respErr),
        .busy       (busy)
`ifdef DMEM_STATS_EN
        ,
        .rd_count   (rdCount),
        .wr_count   (wrCount)
`endif
    );

    dmem_hs #(.DWIDTH(32), .DEPTH(DEPTH_B)) u_dut100 (
        .clk        (clk),
        .rst        (rst),
        .clr        (1'b0),
        .req_valid  (bReqValid),
        .req_ready  (bReqReady),
        .req_we     (bReqWe),
        .req_addr   (bReqAddr),
        .req_wdata  (bReqWdata),
        .req_be     (bReqBe),
        .resp_valid (bRespValid),
        .resp_ready (bRespReady),
        .resp_rdata (bRespRdata),
        .resp_err   (bRespErr),
        .busy       (bBusy)
`ifdef DMEM_STATS_EN
        ,
        .rd_count   (bRdCount),
        .wr_count   (bWrCount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drives one request on the 128-deep instance, waits (bounded) for acceptance and queues the expected response.
    task automatic applyStimulus(input logic we, input logic [6:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] be, input logic [31:0] expRdata, input logic expErr,
                                 input string tag);
        bit accepted = 1'b0;
        @(posedge clk); #1;
        reqWe    = we;
        reqAddr  = addr;
        reqWdata = wdata;
        reqBe    = be;
        reqValid = 1'b1;
        for (int i = 0; i < 400 && !accepted; i++) begin
            @(negedge clk);
            if (reqReady === 1'b1) accepted = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        checkOutput({tag, "_accept"}, 64'(accepted), 64'd1);
        if (accepted) begin
            expQ.push_back({expErr, expRdata});
            @(posedge clk); #1;
            reqValid = 1'b0;
            @(negedge clk);
            checkOutput({tag, "_latency"}, 64'(respValid), 64'd1);
        end else begin
            reqValid = 1'b0;
        end
    endtask

    // Expects DEPTH_A samples of busy with req_ready low, then the memory ready on the next cycle.
    task automatic checkSweep(input string tag);
        int bad = 0;
        for (int i = 0; i < DEPTH_A; i++) begin
            @(negedge clk);
            if (!(busy === 1'b1 && reqReady === 1'b0)) bad++;
        end
        checkOutput({tag, "_busy_cycles"}, 64'(bad), 64'd0);
        @(negedge clk);
        checkOutput({tag, "_ready_after"}, 64'(reqReady), 64'd1);
        checkOutput({tag, "_busy_after"}, 64'(busy), 64'd0);
    endtask

    task automatic bRequest(input logic we, input logic [6:0] addr, input logic [31:0] wdata,
                            input logic [31:0] expRdata, input logic expErr, input string tag);
        @(posedge clk); #1;
        bReqWe    = we;
        bReqAddr  = addr;
        bReqWdata = wdata;
        bReqBe    = 4'hF;
        bReqValid = 1'b1;
        @(negedge clk);
        checkOutput({tag, "_ready"}, 64'(bReqReady), 64'd1);
        @(posedge clk); #1;
        bReqValid = 1'b0;
        @(negedge clk);
        checkOutput({tag, "_valid"}, 64'(bRespValid), 64'd1);
        checkOutput({tag, "_rdata"}, 64'(bRespRdata), 64'(expRdata));
        checkOutput({tag, "_err"}, 64'(bRespErr), 64'(expErr));
    endtask

    // Scoreboard: every completed response handshake must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst && respValid && respReady) begin
            checkOutput("resp_expected", 64'(expQ.size() > 0), 64'd1);
            if (expQ.size() > 0) begin
                expEntry = expQ.pop_front();
                checkOutput("resp_rdata", 64'(respRdata), 64'(expEntry[31:0]));
                checkOutput("resp_err", 64'(respErr), 64'(expEntry[32]));
            end
        end
    end

    initial begin
        rst        = 1'b0;
        clr        = 1'b0;
        reqValid   = 1'b0;
        reqWe      = 1'b0;
        reqAddr    = '0;
        reqWdata   = '0;
        reqBe      = '0;
        respReady  = 1'b1;
        bReqValid  = 1'b0;
        bReqWe     = 1'b0;
        bReqAddr   = '0;
        bReqWdata  = '0;
        bReqBe     = '0;
        bRespReady = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_busy", 64'(busy), 64'd1);
        checkOutput("rst_req_ready", 64'(reqReady), 64'd0);
        checkOutput("rst_resp_valid", 64'(respValid), 64'd0);
        checkOutput("rst_resp_rdata", 64'(respRdata), 64'd0);
        checkOutput("rst_resp_err", 64'(respErr), 64'd0);

        @(posedge clk); #1;
        rst = 1'b1;
        checkSweep("sweep_rst");

        applyStimulus(1'b0, 7'd0,   32'h0, 4'h0, 32'h0, 1'b0, "rd0_zero");
        applyStimulus(1'b0, 7'd77,  32'h0, 4'h0, 32'h0, 1'b0, "rd77_zero");
        applyStimulus(1'b0, 7'd127, 32'h0, 4'h0, 32'h0, 1'b0, "rd127_zero");

        applyStimulus(1'b1, 7'd6, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, "wr6_full");
        applyStimulus(1'b0, 7'd6, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, "rd6_full");
        applyStimulus(1'b1, 7'd6, 32'h11223344, 4'b0101, 32'hDEADBEEF, 1'b0, "wr6_be");
        applyStimulus(1'b0, 7'd6, 32'h0, 4'h0, 32'hDE22BE44, 1'b0, "rd6_be");
        applyStimulus(1'b1, 7'd6, 32'hFFFFFFFF, 4'h0, 32'hDE22BE44, 1'b0, "wr6_be0");

        @(posedge clk); #1;
        respReady = 1'b0;
        applyStimulus(1'b0, 7'd6, 32'h0, 4'h0, 32'hDE22BE44, 1'b0, "rd6_bp");
        reqValid = 1'b1;
        reqWe    = 1'b0;
        reqAddr  = 7'd1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp_hold", 64'(respValid === 1'b1 && respRdata === 32'hDE22BE44 &&
                                       respErr === 1'b0 && reqReady === 1'b0), 64'd1);
        end
        @(posedge clk); #1;
        reqValid  = 1'b0;
        respReady = 1'b1;

        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1'b1, 7'(i), 32'hA0 + 32'(i), 4'hF, 32'h0, 1'b0, "wr_seed");
        end
        @(posedge clk); #1;
        reqValid = 1'b1;
        reqWe    = 1'b0;
        reqBe    = 4'h0;
        for (int i = 1; i <= 3; i++) begin
            reqAddr = 7'(i);
            @(negedge clk);
            checkOutput("b2b_ready", 64'(reqReady), 64'd1);
            if (i > 1) checkOutput("b2b_valid", 64'(respValid), 64'd1);
            expQ.push_back({1'b0, 32'hA0 + 32'(i)});
            @(posedge clk); #1;
        end
        reqValid = 1'b0;
        @(negedge clk);
        checkOutput("b2b_valid_last", 64'(respValid), 64'd1);

        @(posedge clk); #1;
        respReady = 1'b0;
        applyStimulus(1'b0, 7'd6, 32'h0, 4'h0, 32'hDE22BE44, 1'b0, "rd6_clr");
        @(posedge clk); #1;
        clr = 1'b1;
        @(negedge clk);
        checkOutput("clr_resp_busy", 64'(busy), 64'd0);
        checkOutput("clr_resp_valid", 64'(respValid), 64'd1);
        @(posedge clk); #1;
        clr       = 1'b0;
        respReady = 1'b1;
        @(negedge clk);
        checkOutput("clr_pend_busy", 64'(busy), 64'd0);
        checkSweep("sweep_clr");
        applyStimulus(1'b0, 7'd6, 32'h0, 4'h0, 32'h0, 1'b0, "rd6_after_clr");
        applyStimulus(1'b0, 7'd1, 32'h0, 4'h0, 32'h0, 1'b0, "rd1_after_clr");

        applyStimulus(1'b1, 7'd5, 32'h12345678, 4'hF, 32'h0, 1'b0, "wr5");
        applyStimulus(1'b0, 7'd5, 32'h0, 4'h0, 32'h12345678, 1'b0, "rd5");
        @(posedge clk); #1;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        repeat (20) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        checkOutput("midrst_busy", 64'(busy), 64'd1);
        checkOutput("midrst_req_ready", 64'(reqReady), 64'd0);
        checkOutput("midrst_resp_valid", 64'(respValid), 64'd0);
        checkOutput("midrst_resp_rdata", 64'(respRdata), 64'd0);
        checkOutput("midrst_resp_err", 64'(respErr), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        checkSweep("sweep_midrst");

`ifdef DMEM_STATS_EN
        checkOutput("stats_rd_reset", 64'(rdCount), 64'd0);
        checkOutput("stats_wr_reset", 64'(wrCount), 64'd0);
`endif
        applyStimulus(1'b1, 7'd2, 32'h0000BEEF, 4'hF, 32'h0, 1'b0, "stats_wr2");
        applyStimulus(1'b0, 7'd2, 32'h0, 4'h0, 32'h0000BEEF, 1'b0, "stats_rd2");
        applyStimulus(1'b0, 7'd3, 32'h0, 4'h0, 32'h0, 1'b0, "stats_rd3");
`ifdef DMEM_STATS_EN
        checkOutput("stats_rd_count", 64'(rdCount), 64'd2);
        checkOutput("stats_wr_count", 64'(wrCount), 64'd1);
`endif
        @(posedge clk); #1;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        checkSweep("sweep_stats");
`ifdef DMEM_STATS_EN
        checkOutput("stats_rd_clr", 64'(rdCount), 64'd0);
        checkOutput("stats_wr_clr", 64'(wrCount), 64'd0);
`endif

        bRequest(1'b1, 7'd100, 32'h55, 32'h0, 1'b1, "oor_wr100");
        bRequest(1'b0, 7'd99,  32'h0,  32'h0, 1'b0, "oor_rd99");
        bRequest(1'b0, 7'd36,  32'h0,  32'h0, 1'b0, "oor_rd36");
        bRequest(1'b1, 7'd99,  32'h77, 32'h0, 1'b0, "oor_wr99");
        bRequest(1'b0, 7'd99,  32'h0,  32'h77, 1'b0, "oor_rd99b");
        bRequest(1'b0, 7'd100, 32'h0,  32'h0, 1'b1, "oor_rd100");

        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("queue_empty", 64'(expQ.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/dmem_hs.md
Name: dmem_hs

Overview:
- Parametrised successor to the single-cycle data memory.
- Adds configurable width and depth, a valid/ready request/response handshake, byte-enable writes, and out-of-range error reporting.
- Replaces the one-cycle whole-array reset with a sequential zeroing sweep.
- Sits between the processor datapath (address from the ALU or register operand, write data from the register file) and the register-file writeback mux.

Parameters:
- DWIDTH, 32, data word width in bits; must be a multiple of 8.
- DEPTH, 128, number of words; need not be a power of two.
- AWIDTH, $clog2(DEPTH), request address width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-low (0 = reset)
- clr  in  1  synchronous request to re-zero the whole array
- req_valid  in  1  request present
- req_ready  out  1  request accepted on this edge when req_valid is also high
- req_we  in  1  1 = write, 0 = read
- req_addr  in  AWIDTH  word address
- req_wdata  in  DWIDTH  write data
- req_be  in  DWIDTH/8  byte enables for writes; bit i covers bits [8i+7:8i]
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts the response
- resp_rdata  out  DWIDTH  read data; on writes, the word value before the write
- resp_err  out  1  request address was >= DEPTH
- busy  out  1  clear sweep in progress

Behaviour:
- States: CLEAR, IDLE, RESP.
- Reset (rst=0, async):
  - state=CLEAR, sweep pointer=0, clr_pend=0.
  - resp_valid=0, resp_rdata=0, resp_err=0.
  - busy=1, req_ready=0.
  - Array contents are not touched by rst itself; the sweep zeroes them.
- CLEAR:
  - Each cycle writes 0 to mem[ptr] and increments ptr.
  - At ptr==DEPTH-1 the write completes and the next state is IDLE.
  - Sweep takes exactly DEPTH cycles after rst deasserts.
  - busy=1 and req_ready=0 throughout.
  - clr asserted during CLEAR restarts ptr at 0.
- req_ready is combinational: (state==IDLE) || (state==RESP && resp_ready && !clr_pend). This is the only combinational path from resp_ready.
- Accept = req_valid && req_ready.
  - Read: resp_rdata <= mem[addr] at the accepting edge.
  - Write: resp_rdata <= old mem[addr]; bytes with req_be=1 are updated at the same edge, others are preserved.
  - req_be=0 performs no update but still produces a response.
  - After accept: resp_valid=1 from the next cycle, state=RESP. Latency is 1 cycle.
- Out of range (addr >= DEPTH): no write, resp_rdata=0, resp_err=1; otherwise resp_err=0.
- RESP:
  - resp_rdata and resp_err are held stable while resp_valid && !resp_ready.
  - On resp_ready: if a new request is accepted in the same cycle, stay in RESP with new data (full throughput, 1 op/cycle). Otherwise resp_valid <= 0 and go to IDLE, or to CLEAR if clr_pend.
- clr:
  - In IDLE, the next state is CLEAR; a req_valid in the same cycle is not accepted (req_ready is forced low by clr).
  - In RESP, clr sets clr_pend; the pending response is still delivered, then CLEAR. clr_pend is cleared on entry to CLEAR.
- Reset mid-operation: any pending response is dropped (resp_valid=0 immediately) and the sweep restarts.
- Simultaneous write and read of the same address cannot occur (one port, one request per cycle).

Optional Feature:
- Macro: DMEM_STATS_EN.
- Defined:
  - Adds outputs rd_count[15:0] and wr_count[15:0].
  - Each increments on an accepted in-range read or write, respectively.
  - Both saturate at 16'hFFFF.
  - Zeroed by rst and on entry to CLEAR.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package dmem_pkg:
  - dmem_state_t enum {CLEAR, IDLE, RESP}.
  - Default constants DMEM_DWIDTH=32, DMEM_DEPTH=128.
  - A byte-merge function (old, new, be) -> word.
- One sub-module, dmem_clear_seq: holds the sweep pointer, restart, and done logic; outputs ptr, the clear write enable, and done.

Test Plan:
- Reset release, DEPTH=128: busy=1 and req_ready=0 for 128 cycles; req_ready=1 on cycle 129; reading any address returns 0.
- Write addr 6 data 32'hDEADBEEF be=4'hF: response rdata=0, err=0. Then read addr 6: rdata=32'hDEADBEEF one cycle after accept.
- Byte-enable write: write addr 6 data 32'h11223344 be=4'b0101, response rdata=32'hDEADBEEF. Read addr 6 -> 32'hDE22BE44.
- Backpressure: hold resp_ready=0 for 5 cycles after a read; resp_valid, resp_rdata and resp_err stay stable and req_ready=0. Then back-to-back reads of addrs 1,2,3 with resp_ready=1 give 3 responses in 3 consecutive cycles.
- Out of range, DEPTH=100: write addr 100 data 32'h55 -> err=1, rdata=0. Read addr 99 -> 0, confirming no aliasing of the write.
- clr during RESP with resp_ready=0: response is still delivered on handshake, then busy=1 for DEPTH cycles, then addr 6 reads 0. Async rst pulse mid-sweep: outputs return to reset values immediately and a full DEPTH-cycle sweep follows. With DMEM_STATS_EN: 2 reads and 1 write give rd_count=2, wr_count=1, and both counters are 0 after clr.
